offload_unit: RTL and testbench
===============================

// Module: offload_unit
// PURPOSE
//  Parametrised dispatcher for long-latency execute-stage operations: FPU ops, IO in/out and future coprocessors.
//  Replaces the single-op stall handshake with in-order tracking of up to DEPTH outstanding requests over NCH
//  valid/ready channels, in-order writeback and a scoreboard port for the hazard unit.
//  Sits between the CPU execute stage and the FPU/IO blocks; its writeback feeds the GP/FP regfile write port.
// PARAMETERS
//  NCH    4   number of channels (ch 0 = FPU, 1 = IO out, 2 = IO in, 3 = spare); CW = max(1, $clog2(NCH))
//  DW     32  operand/result width
//  RW     5   register address width
//  OPW    4   opcode width forwarded to channels
//  DEPTH  4   max outstanding requests, power of 2, >= 2
// PORTS
//  clk          in   1        clock
//  rstn         in   1        synchronous active-low reset
//  req_vld      in   1        execute stage offers an op
//  req_rdy      out  1        op accepted when req_vld && req_rdy
//  req_ch       in   CW       target channel
//  req_op       in   OPW      channel opcode
//  req_a        in   DW       operand 1
//  req_b        in   DW       operand 2
//  req_rd       in   RW       destination register
//  req_rd_f     in   1        destination is FP regfile
//  req_wb       in   1        result is written back (0: retire silently, e.g. IO out)
//  ch_in_vld    out  NCH      one-hot request valid
//  ch_in_rdy    in   NCH      channel accepts request
//  ch_op        out  OPW      shared request opcode
//  ch_a, ch_b   out  DW       shared request operands
//  ch_out_vld   in   NCH      channel result valid
//  ch_out_rdy   out  NCH      one-hot result ready
//  ch_out_data  in   NCH*DW   channel results; ch i at [i*DW +: DW]
//  wb_vld       out  1        writeback valid
//  wb_rdy       in   1        regfile takes writeback
//  wb_data      out  DW       writeback value
//  wb_rd        out  RW       writeback register
//  wb_rd_f      out  1        writeback targets FP regfile
//  sb_rd        in   RW       scoreboard query register
//  sb_f         in   1        scoreboard query regfile select
//  sb_hit       out  1        comb: pending writeback to {sb_f, sb_rd}
//  busy         out  1        any entry outstanding or dispatch held
//  err          out  2        sticky: [0] bad channel, [1] unexpected ch_out_vld
//  err_clr      in   1        clears err on next edge
// BEHAVIOUR
//  Reset: all vld/rdy outputs, busy, err, queue count 0; ch_op/ch_a/ch_b/wb_data/wb_rd/wb_rd_f 0. Reset mid-operation
//   discards all entries; abandoned channel handshakes are the channels' concern.
//  Tracking FIFO: DEPTH entries {ch, rd, rd_f, wb, issued}; wr/rd pointers wrap mod DEPTH; count 0..DEPTH.
//  Dispatch register: one op. req_rdy = (count < DEPTH) && !disp_vld; registered-free comb of state only.
//  Accept at edge T: entry pushed, dispatch register loaded; ch_in_vld[req_ch] = 1 from T+1, op/a/b stable
//   until ch_in_rdy[ch] seen high at an edge; then disp_vld clears and entry.issued = 1. Earliest next accept: next cycle.
//  req_ch >= NCH: request consumed (req_rdy still high), not queued, err[0] set.
//  Completion, strictly in order: ch_out_rdy[head.ch] = 1 only when head valid, head.issued and result register
//   empty; all other ch_out_rdy bits are 0.
//  Result capture: on ch_out_vld && ch_out_rdy, data goes to result register. wb = 1 -> wb_vld = 1 next cycle,
//   held with stable data until wb_rdy, then head pops. wb = 0 -> head pops at the capture edge, no wb_vld.
//  ch_out_vld high on a channel with no issued entry: err[1] set, value ignored.
//  Push and pop on the same edge: count unchanged, both pointers advance.
//  Minimum latency, channel answering in the cycle after dispatch: accept T, ch_in handshake T+1,
//   ch_out handshake T+2, wb_vld T+3.
//  sb_hit = OR over valid entries with wb = 1 of ({rd_f, rd} == {sb_f, sb_rd}), including the entry in wb
//   until its pop edge. Query {0, 0} never hits.
//  busy = (count != 0) || disp_vld. err_clr and a new error on the same edge: error bit ends set.
// TESTING
//  FPU op ch0, rd = 5 f = 1, FPU in_rdy = 1, result 0x3F800000 one cycle later -> wb_vld at T+3, wb_rd 5, f 1;
//   sb_hit for {1, 5} T+1..pop.
//  4 back-to-back ops on ch0/ch2 with ch2 answering first -> ch2 result held off, writebacks in issue order;
//   5th req_rdy = 0 until first pop.
//  IO out ch1, wb = 0, out_rdy delayed 10 cycles -> ch_in_vld[1] held 10 cycles, no wb_vld, busy drops after retire.
//  wb_rdy low 5 cycles with 2 pending -> wb_data stable, second result not captured, no loss.
//  req_ch = 3 with NCH = 3 -> consumed, err = 2'b01; err_clr -> 0; spurious ch_out_vld[2] -> err = 2'b10.
//  rstn low mid-flight with 3 outstanding -> next cycle all vld 0, busy 0, sb_hit 0, req_rdy 1.

Source files
------------

// File: rtl/offload_unit.sv
// offload_unit: in-order dispatcher for long-latency execute-stage operations.
// Requests are queued in a tracking FIFO, dispatched one at a time to NCH
// valid/ready channels, and their results are written back in issue order.
// A scoreboard query reports pending writebacks to the hazard unit.
module offload_unit #(
   parameter  int NCH   = 4,
   parameter  int DW    = 32,
   parameter  int RW    = 5,
   parameter  int OPW   = 4,
   parameter  int DEPTH = 4,
   localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req_vld,
   output logic              req_rdy,
   input  logic [CW-1:0]     req_ch,
   input  logic [OPW-1:0]    req_op,
   input  logic [DW-1:0]     req_a,
   input  logic [DW-1:0]     req_b,
   input  logic [RW-1:0]     req_rd,
   input  logic              req_rd_f,
   input  logic              req_wb,
   output logic [NCH-1:0]    ch_in_vld,
   input  logic [NCH-1:0]    ch_in_rdy,
   output logic [OPW-1:0]    ch_op,
   output logic [DW-1:0]     ch_a,
   output logic [DW-1:0]     ch_b,
   input  logic [NCH-1:0]    ch_out_vld,
   output logic [NCH-1:0]    ch_out_rdy,
   input  logic [NCH*DW-1:0] ch_out_data,
   output logic              wb_vld,
   input  logic              wb_rdy,
   output logic [DW-1:0]     wb_data,
   output logic [RW-1:0]     wb_rd,
   output logic              wb_rd_f,
   input  logic [RW-1:0]     sb_rd,
   input  logic              sb_f,
   output logic              sb_hit,
   output logic              busy,
   output logic [1:0]        err,
   input  logic              err_clr
);

   // tracking FIFO, one slot per outstanding request
   logic [CW-1:0]    e_ch  [DEPTH];
   logic [RW-1:0]    e_rd  [DEPTH];
   logic [DEPTH-1:0] e_rd_f;
   logic [DEPTH-1:0] e_wb;
   logic [DEPTH-1:0] e_iss;
   logic [DEPTH-1:0] e_vld;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;

   // single-op dispatch register; disp_idx is the FIFO slot it belongs to
   logic             disp_vld;
   logic [CW-1:0]    disp_ch;
   logic [PW-1:0]    disp_idx;

   logic             bad_ch;
   logic             accept;
   logic             push;
   logic             issue;
   logic             head_wb;
   logic             cap;
   logic             pop;
   logic             spur;
   logic [NCH-1:0]   ch_iss;
   logic [DW-1:0]    res_sel;

   assign req_rdy   = (count != (PW+1)'(DEPTH)) && !disp_vld;
   assign bad_ch    = {1'b0, req_ch} >= (CW+1)'(NCH);
   assign accept    = req_vld && req_rdy;
   assign push      = accept && !bad_ch;
   assign issue     = disp_vld && ch_in_rdy[disp_ch];
   assign ch_in_vld = disp_vld ? (NCH'(1) << disp_ch) : '0;
   assign head_wb   = e_wb[rd_ptr];
   // the head may only collect its result once issued and the result register is free
   assign ch_out_rdy = (e_vld[rd_ptr] && e_iss[rd_ptr] && !wb_vld) ? (NCH'(1) << e_ch[rd_ptr]) : '0;
   assign cap       = |(ch_out_vld & ch_out_rdy);
   assign pop       = (cap && !head_wb) || (wb_vld && wb_rdy);
   assign spur      = |(ch_out_vld & ~ch_iss);
   assign busy      = (count != '0) || disp_vld;

   // per-channel "has an issued entry" flags and head result select
   always_comb begin
      ch_iss  = '0;
      res_sel = '0;
      for (int i = 0; i < NCH; i++) begin
         for (int j = 0; j < DEPTH; j++) begin
            if (e_vld[j] && e_iss[j] && (e_ch[j] == CW'(i))) ch_iss[i] = 1'b1;
         end
         if (e_ch[rd_ptr] == CW'(i)) res_sel = ch_out_data[i*DW +: DW];
      end
   end

   // scoreboard: any live entry that will write {sb_f, sb_rd}; x0 is never a hazard
   always_comb begin
      sb_hit = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
         if (e_vld[j] && e_wb[j] && (e_rd_f[j] == sb_f) && (e_rd[j] == sb_rd)) sb_hit = 1'b1;
      end
      if ({sb_f, sb_rd} == '0) sb_hit = 1'b0;
   end

   // queue, dispatch, result register and sticky error state
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int j = 0; j < DEPTH; j++) begin
            e_ch[j] <= '0;
            e_rd[j] <= '0;
         end
         e_rd_f   <= '0;
         e_wb     <= '0;
         e_iss    <= '0;
         e_vld    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         disp_vld <= 1'b0;
         disp_ch  <= '0;
         disp_idx <= '0;
         ch_op    <= '0;
         ch_a     <= '0;
         ch_b     <= '0;
         wb_vld   <= 1'b0;
         wb_data  <= '0;
         wb_rd    <= '0;
         wb_rd_f  <= 1'b0;
         err      <= '0;
      end else begin
         if (push) begin
            e_ch[wr_ptr]   <= req_ch;
            e_rd[wr_ptr]   <= req_rd;
            e_rd_f[wr_ptr] <= req_rd_f;
            e_wb[wr_ptr]   <= req_wb;
            e_iss[wr_ptr]  <= 1'b0;
            e_vld[wr_ptr]  <= 1'b1;
            wr_ptr         <= wr_ptr + 1'b1;
            disp_vld       <= 1'b1;
            disp_ch        <= req_ch;
            disp_idx       <= wr_ptr;
            ch_op          <= req_op;
            ch_a           <= req_a;
            ch_b           <= req_b;
         end
         // push and issue never coincide: accepting needs the dispatch register empty
         if (issue) begin
            disp_vld        <= 1'b0;
            e_iss[disp_idx] <= 1'b1;
         end
         if (pop) begin
            e_vld[rd_ptr] <= 1'b0;
            rd_ptr        <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (cap && head_wb) begin
            wb_vld  <= 1'b1;
            wb_data <= res_sel;
            wb_rd   <= e_rd[rd_ptr];
            wb_rd_f <= e_rd_f[rd_ptr];
         end else if (wb_vld && wb_rdy) begin
            wb_vld  <= 1'b0;
         end
         err <= (err & ~{2{err_clr}}) | {spur, accept && bad_ch};
      end
   end

endmodule

// File: tb/tb_offload_unit.sv
// Directed bench for offload_unit (NCH = 3 so channel code 3 is invalid).
module tb_offload_unit;

   localparam int NCH = 3;
   localparam int DW  = 32;
   localparam logic [31:0] F0 = 32'h3F80_0000;
   localparam logic [31:0] D1 = 32'h1111_1111;
   localparam logic [31:0] D2 = 32'h2222_2222;

   logic              clk = 1'b0;
   logic              rstn;
   logic              req_vld;
   logic              req_rdy;
   logic [1:0]        req_ch;
   logic [3:0]        req_op;
   logic [31:0]       req_a;
   logic [31:0]       req_b;
   logic [4:0]        req_rd;
   logic              req_rd_f;
   logic              req_wb;
   logic [NCH-1:0]    ch_in_vld;
   logic [NCH-1:0]    ch_in_rdy;
   logic [3:0]        ch_op;
   logic [31:0]       ch_a;
   logic [31:0]       ch_b;
   logic [NCH-1:0]    ch_out_vld;
   logic [NCH-1:0]    ch_out_rdy;
   logic [NCH*DW-1:0] ch_out_data;
   logic              wb_vld;
   logic              wb_rdy;
   logic [31:0]       wb_data;
   logic [4:0]        wb_rd;
   logic              wb_rd_f;
   logic [4:0]        sb_rd;
   logic              sb_f;
   logic              sb_hit;
   logic              busy;
   logic [1:0]        err;
   logic              err_clr;

   int n_vec = 0;
   int n_err = 0;

   offload_unit #(.NCH(NCH), .DW(DW), .RW(5), .OPW(4), .DEPTH(4)) dut (
      .clk(clk), .rstn(rstn),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_ch(req_ch), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .req_rd_f(req_rd_f), .req_wb(req_wb),
      .ch_in_vld(ch_in_vld), .ch_in_rdy(ch_in_rdy), .ch_op(ch_op), .ch_a(ch_a), .ch_b(ch_b),
      .ch_out_vld(ch_out_vld), .ch_out_rdy(ch_out_rdy), .ch_out_data(ch_out_data),
      .wb_vld(wb_vld), .wb_rdy(wb_rdy), .wb_data(wb_data), .wb_rd(wb_rd), .wb_rd_f(wb_rd_f),
      .sb_rd(sb_rd), .sb_f(sb_f), .sb_hit(sb_hit), .busy(busy), .err(err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rv;
      logic [1:0]  rc;
      logic [4:0]  rd;
      logic        rf;
      logic        rw;
      logic [2:0]  irdy;
      logic [2:0]  ovld;
      logic        wrdy;
      logic [5:0]  sbq;
      logic        clr;
      logic        rrdy;
      logic [2:0]  ivld;
      logic [2:0]  ordy;
      logic        wvld;
      logic [4:0]  wrd;
      logic [31:0] wdat;
      logic        hit;
      logic        bsy;
      logic [1:0]  er;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      input logic rv, input logic [1:0] rc, input logic [4:0] rd, input logic rf, input logic rw,
      input logic [2:0] irdy, input logic [2:0] ovld, input logic wrdy, input logic [5:0] sbq,
      input logic clr, input logic rrdy, input logic [2:0] ivld, input logic [2:0] ordy,
      input logic wvld, input logic [4:0] wrd, input logic [31:0] wdat, input logic hit,
      input logic bsy, input logic [1:0] er);
      vec_t v;
      v.rv = rv; v.rc = rc; v.rd = rd; v.rf = rf; v.rw = rw;
      v.irdy = irdy; v.ovld = ovld; v.wrdy = wrdy; v.sbq = sbq; v.clr = clr;
      v.rrdy = rrdy; v.ivld = ivld; v.ordy = ordy; v.wvld = wvld; v.wrd = wrd;
      v.wdat = wdat; v.hit = hit; v.bsy = bsy; v.er = er;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      req_vld = 0; req_ch = 0; req_op = 0; req_a = 0; req_b = 0;
      req_rd = 0; req_rd_f = 0; req_wb = 0;
      ch_in_rdy = 0; ch_out_vld = 0; wb_rdy = 0;
      sb_rd = 0; sb_f = 0; err_clr = 0;
   endtask

   initial begin
      //       rv rc rd  rf rw irdy ovld wr sbq    clr| rrdy ivld ordy wv wrd wdat hit bsy err
      // single FPU op, minimum latency
      tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 6'h25, 0, 1, 3'b000, 3'b000, 0, 0, 0,  0, 0, 2'b00));
      tbl.push_back(mk(1, 0, 5, 1, 1, 3'b000, 3'b000, 0, 6'h25, 0, 1, 3'b000, 3'b000, 0, 0, 0,  0, 0, 2'b00));
      tbl.push_back(mk(0, 0, 0, 0, 0, 3'b001, 3'b000, 0, 6'h25, 0, 0, 3'b001, 3'b000, 0, 0, 0,  1, 1, 2'b00));
      tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b001, 0, 6'h25, 0, 1, 3'b000, 3'b001, 0, 0, 0,  1, 1, 2'b00));
      tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 6'h25, 0, 1, 3'b000, 3'b000, 1, 5, F0, 1, 1, 2'b00));
      tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 1, 6'h25, 0, 1, 3'b000, 3'b000, 1, 5, F0, 1, 1, 2'b00));
      tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 6'h25, 0, 1, 3'b000, 3'b000, 0, 0, 0,  0, 0, 2'b00));
      // four ops ch0/ch2/ch0/ch2, ch2 answers first, fifth held off
      tbl.push_back(mk(1, 0, 1, 0, 1, 3'b101, 3'b000, 0, 6'h02, 0, 1, 3'b000, 3'b000, 0, 0, 0,  0, 0, 2'b00));
      tbl.push_back(mk(1, 2, 2, 0, 1, 3'b101, 3'b000, 0, 6'h02, 0, 0, 3'b001, 3'b000, 0, 0, 0,  0, 1, 2'b00));
      tbl.push_back(mk(1, 2, 2, 0, 1, 3'b101, 3'b000, 0, 6'h02, 0, 1, 3'b000, 3'b001, 0, 0, 0,  0, 1, 2'b00));
      tbl.push_back(mk(1, 0, 3, 0, 1, 3'b101, 3'b000, 0, 6'h02, 0, 0, 3'b100, 3'b001, 0, 0, 0,  1, 1, 2'b00));
      tbl.push_back(mk(1, 0, 3, 0, 1, 3'b101, 3'b100, 0, 6'h02, 0, 1, 3'b000, 3'b001, 0, 0, 0,  1, 1, 2'b00));
      tbl.push_back(mk(1, 2, 4, 0, 1, 3'b101, 3'b100, 0, 6'h02, 0, 0, 3'b001, 3'b001, 0, 0, 0,  1, 1, 2'b00));
      tbl.push_back(mk(1, 2, 4, 0, 1, 3'b101, 3'b100, 0, 6'h02, 0, 1, 3'b000, 3'b001, 0, 0, 0,  1, 1, 2'b00));
      tbl.push_back(mk(1, 0, 6, 0, 1, 3'b101, 3'b100, 0, 6'h02, 0, 0, 3'b100, 3'b001, 0, 0, 0,  1, 1, 2'b00));
      tbl.push_back(mk(1, 0, 6, 0, 1, 3'b101, 3'b101, 0, 6'h02, 0, 0, 3'b000, 3'b001, 0, 0, 0,  1, 1, 2'b00));
      tbl.push_back(mk(1, 0, 6, 0, 1, 3'b101, 3'b100, 1, 6'h02, 0, 0, 3'b000, 3'b000, 1, 1, F0, 1, 1, 2'b00));
      tbl.push_back(mk(0, 0, 0, 0, 0, 3'b101, 3'b100, 0, 6'h02, 0, 1, 3'b000, 3'b100, 0, 0, 0,  1, 1, 2'b00));
      tbl.push_back(mk(0, 0, 0, 0, 0, 3'b101, 3'b000, 1, 6'h02, 0, 1, 3'b000, 3'b000, 1, 2, D2, 1, 1, 2'b00));
      tbl.push_back(mk(0, 0, 0, 0, 0, 3'b101, 3'b001, 0, 6'h02, 0, 1, 3'b000, 3'b001, 0, 0, 0,  0, 1, 2'b00));
      tbl.push_back(mk(0, 0, 0, 0, 0, 3'b101, 3'b100, 1, 6'h02, 0, 1, 3'b000, 3'b000, 1, 3, F0, 0, 1, 2'b00));
      tbl.push_back(mk(0, 0, 0, 0, 0, 3'b101, 3'b100, 0, 6'h02, 0, 1, 3'b000, 3'b100, 0, 0, 0,  0, 1, 2'b00));
      tbl.push_back(mk(0, 0, 0, 0, 0, 3'b101, 3'b000, 1, 6'h02, 0, 1, 3'b000, 3'b000, 1, 4, D2, 0, 1, 2'b00));
      tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 6'h02, 0, 1, 3'b000, 3'b000, 0, 0, 0,  0, 0, 2'b00));
      // bad channel, clear, spurious result, clear racing a new error
      tbl.push_back(mk(1, 3, 7, 0, 1, 3'b000, 3'b000, 0, 6'h00, 0, 1, 3'b000, 3'b000, 0, 0, 0,  0, 0, 2'b00));
      tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 6'h00, 0, 1, 3'b000, 3'b000, 0, 0, 0,  0, 0, 2'b01));
      tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 6'h00, 1, 1, 3'b000, 3'b000, 0, 0, 0,  0, 0, 2'b01));
      tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b100, 0, 6'h00, 0, 1, 3'b000, 3'b000, 0, 0, 0,  0, 0, 2'b00));
      tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 6'h00, 0, 1, 3'b000, 3'b000, 0, 0, 0,  0, 0, 2'b10));
      tbl.push_back(mk(1, 3, 0, 0, 0, 3'b000, 3'b000, 0, 6'h00, 1, 1, 3'b000, 3'b000, 0, 0, 0,  0, 0, 2'b10));
      tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 6'h00, 0, 1, 3'b000, 3'b000, 0, 0, 0,  0, 0, 2'b01));
      tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 6'h00, 1, 1, 3'b000, 3'b000, 0, 0, 0,  0, 0, 2'b01));
      tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 6'h00, 0, 1, 3'b000, 3'b000, 0, 0, 0,  0, 0, 2'b00));

      ch_out_data = {D2, D1, F0};
      idle_inputs();
      rstn = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst req_rdy", 32'(req_rdy), 1);
      chk("rst ch_in_vld", 32'(ch_in_vld), 0);
      chk("rst wb_vld", 32'(wb_vld), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst err", 32'(err), 0);
      chk("rst ch_a", ch_a, 0);
      chk("rst wb_data", wb_data, 0);
      @(negedge clk);
      rstn = 1;

      for (int i = 0; i < tbl.size(); i++) begin
         if (i != 0) @(negedge clk);
         req_vld = tbl[i].rv; req_ch = tbl[i].rc; req_rd = tbl[i].rd;
         req_rd_f = tbl[i].rf; req_wb = tbl[i].rw;
         ch_in_rdy = tbl[i].irdy; ch_out_vld = tbl[i].ovld; wb_rdy = tbl[i].wrdy;
         {sb_f, sb_rd} = tbl[i].sbq; err_clr = tbl[i].clr;
         #1;
         chk($sformatf("v%0d req_rdy", i), 32'(req_rdy), 32'(tbl[i].rrdy));
         chk($sformatf("v%0d ch_in_vld", i), 32'(ch_in_vld), 32'(tbl[i].ivld));
         chk($sformatf("v%0d ch_out_rdy", i), 32'(ch_out_rdy), 32'(tbl[i].ordy));
         chk($sformatf("v%0d wb_vld", i), 32'(wb_vld), 32'(tbl[i].wvld));
         if (tbl[i].wvld) begin
            chk($sformatf("v%0d wb_rd", i), 32'(wb_rd), 32'(tbl[i].wrd));
            chk($sformatf("v%0d wb_data", i), wb_data, tbl[i].wdat);
         end
         chk($sformatf("v%0d sb_hit", i), 32'(sb_hit), 32'(tbl[i].hit));
         chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].bsy));
         chk($sformatf("v%0d err", i), 32'(err), 32'(tbl[i].er));
      end
      chk("fpu wb_rd_f seen", 32'(wb_rd_f), 0);

      // IO out on ch1, no writeback, channel slow to accept
      @(negedge clk);
      idle_inputs();
      req_vld = 1; req_ch = 1; req_rd = 9; req_wb = 0;
      req_op = 4'hA; req_a = 32'hDEAD_0001; req_b = 32'hBEEF_0002;
      sb_rd = 9;
      @(negedge clk);
      req_vld = 0; req_op = 0; req_a = 0; req_b = 0;
      for (int k = 0; k < 9; k++) begin
         #1;
         chk($sformatf("io%0d ch_in_vld", k), 32'(ch_in_vld), 32'b010);
         chk($sformatf("io%0d ch_a", k), ch_a, 32'hDEAD_0001);
         chk($sformatf("io%0d ch_b", k), ch_b, 32'hBEEF_0002);
         chk($sformatf("io%0d ch_op", k), 32'(ch_op), 32'hA);
         chk($sformatf("io%0d sb_hit", k), 32'(sb_hit), 0);
         chk($sformatf("io%0d busy", k), 32'(busy), 1);
         @(negedge clk);
      end
      ch_in_rdy = 3'b010;
      #1 chk("io hs ch_in_vld", 32'(ch_in_vld), 32'b010);
      @(negedge clk);
      ch_in_rdy = 0;
      #1;
      chk("io ch_in_vld off", 32'(ch_in_vld), 0);
      chk("io ch_out_rdy", 32'(ch_out_rdy), 32'b010);
      chk("io busy pending", 32'(busy), 1);
      ch_out_vld = 3'b010;
      @(negedge clk);
      ch_out_vld = 0;
      #1;
      chk("io retired busy", 32'(busy), 0);
      chk("io no wb_vld", 32'(wb_vld), 0);
      chk("io ch_out_rdy off", 32'(ch_out_rdy), 0);
      chk("io err", 32'(err), 0);

      // writeback stalled with two results pending
      @(negedge clk);
      req_vld = 1; req_ch = 0; req_rd = 10; req_rd_f = 1; req_wb = 1;
      ch_in_rdy = 3'b001; wb_rdy = 0; sb_f = 1; sb_rd = 11;
      @(negedge clk);
      req_vld = 0;
      @(negedge clk);
      req_vld = 1; req_rd = 11;
      @(negedge clk);
      req_vld = 0;
      ch_out_data[31:0] = 32'hAAAA_0001; ch_out_vld = 3'b001;
      @(negedge clk);
      ch_out_data[31:0] = 32'hAAAA_0002;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("st%0d wb_vld", k), 32'(wb_vld), 1);
         chk($sformatf("st%0d wb_data", k), wb_data, 32'hAAAA_0001);
         chk($sformatf("st%0d wb_rd", k), 32'(wb_rd), 10);
         chk($sformatf("st%0d wb_rd_f", k), 32'(wb_rd_f), 1);
         chk($sformatf("st%0d ch_out_rdy", k), 32'(ch_out_rdy), 0);
         chk($sformatf("st%0d sb_hit", k), 32'(sb_hit), 1);
         @(negedge clk);
      end
      wb_rdy = 1;
      @(negedge clk);
      wb_rdy = 0;
      #1;
      chk("st gap wb_vld", 32'(wb_vld), 0);
      chk("st gap ch_out_rdy", 32'(ch_out_rdy), 32'b001);
      @(negedge clk);
      #1;
      chk("st 2nd wb_vld", 32'(wb_vld), 1);
      chk("st 2nd wb_data", wb_data, 32'hAAAA_0002);
      chk("st 2nd wb_rd", 32'(wb_rd), 11);
      wb_rdy = 1; ch_out_vld = 0;
      @(negedge clk);
      wb_rdy = 0;
      #1;
      chk("st done busy", 32'(busy), 0);
      chk("st done sb_hit", 32'(sb_hit), 0);
      chk("st done err", 32'(err), 0);

      // reset with three requests outstanding
      ch_in_rdy = 3'b001; req_ch = 0; req_rd_f = 0; req_wb = 1; req_a = 32'h5;
      req_vld = 1; req_rd = 12;
      @(negedge clk);
      req_vld = 0;
      @(negedge clk);
      req_vld = 1; req_rd = 13;
      @(negedge clk);
      req_vld = 0;
      @(negedge clk);
      req_vld = 1; req_rd = 14; ch_in_rdy = 0;
      @(negedge clk);
      req_vld = 0; sb_f = 0; sb_rd = 13;
      #1;
      chk("pre-rst busy", 32'(busy), 1);
      chk("pre-rst sb_hit", 32'(sb_hit), 1);
      chk("pre-rst ch_in_vld", 32'(ch_in_vld), 32'b001);
      rstn = 0;
      @(negedge clk);
      rstn = 1;
      #1;
      chk("mid-rst ch_in_vld", 32'(ch_in_vld), 0);
      chk("mid-rst ch_out_rdy", 32'(ch_out_rdy), 0);
      chk("mid-rst wb_vld", 32'(wb_vld), 0);
      chk("mid-rst busy", 32'(busy), 0);
      chk("mid-rst sb_hit", 32'(sb_hit), 0);
      chk("mid-rst req_rdy", 32'(req_rdy), 1);
      chk("mid-rst ch_a", ch_a, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
